// File: rtl/dip_serial_source.sv
// dip_serial_source
//
// Serialises a 21-bit word built from a DIP switch bank and a push-switch
// bank. The word is sent MSB first, and each bit is held for DIV clock
// cycles. A load request comes from an asynchronous latch strobe, which is
// synchronised and edge-detected inside this block.
//
// Optional feature (macro DIP_SERIAL_PARITY_EN):
//   When the macro is defined, one even-parity bit over the 21 data bits is
//   appended after W[0], which makes the frame 22 bits long. When it is not
//   defined, the frame is 21 bits and there is no parity logic.
//
// Parameters:
//   DIV       cycles each serial bit is held (1..255)
//   IDLE_LVL  level driven on o_DIPData while no frame is in progress
//
// Ports:
//   i_CLK        clock, all state updates on the rising edge
//   i_RESET_n    asynchronous active-low reset
//   i_DIP16      DIP switch value, sampled at load
//   i_Switch5    push-switch value, sampled at load
//   i_DIPLatch   load request, asynchronous to i_CLK
//   o_DIPData    serial frame data
//   o_Busy       high while a frame is shifting
//   o_FrameDone  one-cycle pulse after the last bit of a frame
//   o_BitCnt     index of the bit currently on o_DIPData, 0 when idle

module dip_serial_source #(
  parameter int unsigned DIV      = 1,
  parameter logic        IDLE_LVL = 1'b1
) (
  input  logic        i_CLK,
  input  logic        i_RESET_n,
  input  logic [15:0] i_DIP16,
  input  logic [4:0]  i_Switch5,
  input  logic        i_DIPLatch,
  output logic        o_DIPData,
  output logic        o_Busy,
  output logic        o_FrameDone,
  output logic [4:0]  o_BitCnt
);

`ifdef DIP_SERIAL_PARITY_EN
  localparam int FRAME_LEN = 22;
`else
  localparam int FRAME_LEN = 21;
`endif

  localparam logic [4:0] LAST_BIT = 5'(FRAME_LEN - 1);
  localparam logic [7:0] PRE_MAX  = 8'(DIV - 1);

  typedef enum logic {
    IDLE,
    SHIFT
  } state_t;

  state_t state, state_next;

  logic                 latch_s1, latch_s2, latch_d;
  logic                 sync_v1, sync_v2;
  logic                 armed;
  logic                 load;
  logic [FRAME_LEN-1:0] frame_word;
  logic [FRAME_LEN-1:0] shreg;
  logic [4:0]           bit_cnt;
  logic [7:0]           pre_cnt;
  logic                 bit_end;
  logic                 frame_end;
  logic                 frame_done;

  // Two-flop synchroniser followed by a rising-edge detector. sync_v1/v2
  // mark when latch_s2 holds a real sample rather than its reset value.
  // armed is set only after the synchronised strobe has been seen low.
  // Because of this, a strobe that is already high when reset releases
  // does not produce a load until it has dropped and risen again.
  always_ff @(posedge i_CLK or negedge i_RESET_n) begin
    if (!i_RESET_n) begin
      latch_s1 <= 1'b0;
      latch_s2 <= 1'b0;
      latch_d  <= 1'b0;
      sync_v1  <= 1'b0;
      sync_v2  <= 1'b0;
      armed    <= 1'b0;
    end else begin
      latch_s1 <= i_DIPLatch;
      latch_s2 <= latch_s1;
      latch_d  <= latch_s2;
      sync_v1  <= 1'b1;
      sync_v2  <= sync_v1;
      if (sync_v2 && !latch_s2) begin
        armed <= 1'b1;
      end
    end
  end

  assign load = armed & latch_s2 & ~latch_d;

`ifdef DIP_SERIAL_PARITY_EN
  assign frame_word = {i_Switch5, i_DIP16, ^{i_Switch5, i_DIP16}};
`else
  assign frame_word = {i_Switch5, i_DIP16};
`endif

  assign bit_end   = (pre_cnt == PRE_MAX);
  assign frame_end = (state == SHIFT) && bit_end && (bit_cnt == LAST_BIT);

  always_ff @(posedge i_CLK or negedge i_RESET_n) begin
    if (!i_RESET_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // A load always wins. It starts a frame from idle, and it restarts a frame
  // that is already shifting, including the frame's final cycle.
  always_comb begin
    state_next  = state;
    o_Busy      = 1'b0;
    o_DIPData   = IDLE_LVL;
    case (state)
      IDLE: begin
        if (load) begin
          state_next = SHIFT;
        end
      end
      SHIFT: begin
        o_Busy    = 1'b1;
        o_DIPData = shreg[FRAME_LEN-1];
        if (load) begin
          state_next = SHIFT;
        end else if (frame_end) begin
          state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Shift datapath. The prescale counter restarts on every load. The pulse
  // follows frame_end, so an aborted frame never reports completion. A
  // restart that lands on the final cycle still reports it.
  always_ff @(posedge i_CLK or negedge i_RESET_n) begin
    if (!i_RESET_n) begin
      shreg      <= '0;
      bit_cnt    <= 5'd0;
      pre_cnt    <= 8'd0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= frame_end;
      if (load) begin
        shreg   <= frame_word;
        bit_cnt <= 5'd0;
        pre_cnt <= 8'd0;
      end else if (state == SHIFT) begin
        if (bit_end) begin
          pre_cnt <= 8'd0;
          if (bit_cnt == LAST_BIT) begin
            bit_cnt <= 5'd0;
          end else begin
            bit_cnt <= bit_cnt + 5'd1;
            shreg   <= {shreg[FRAME_LEN-2:0], 1'b0};
          end
        end else begin
          pre_cnt <= pre_cnt + 8'd1;
        end
      end
    end
  end

  assign o_FrameDone = frame_done;
  assign o_BitCnt    = bit_cnt;

endmodule

// File: tb/tb_dip_serial_source.sv
// tb_dip_serial_source
//
// Drives two instances of dip_serial_source from a shared set of inputs:
//   lane 0  DIV=1, IDLE_LVL=1
//   lane 1  DIV=4, IDLE_LVL=0
//
// Each load request is pushed into a per-lane queue, together with the cycle
// in which its frame should begin. A monitor per lane pops entries when their
// start cycle arrives. It derives the expected outputs from elapsed time:
//   bit index   = elapsed / DIV
//   frame done  = elapsed reaching frame length * DIV
// It then compares these against the DUT on every falling edge.
// Frame length follows DIP_SERIAL_PARITY_EN in the same way as the design.

module tb_dip_serial_source;

`ifdef DIP_SERIAL_PARITY_EN
  localparam int L = 22;
`else
  localparam int L = 21;
`endif

  typedef struct {
    logic [20:0] w;
    int          start;
  } load_t;

  logic        clk   = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] dip   = 16'h0000;
  logic [4:0]  sw    = 5'd0;
  logic        latch = 1'b0;

  logic        data_o [2];
  logic        busy_o [2];
  logic        done_o [2];
  logic [4:0]  bcnt_o [2];

  int    cyc      = 0;
  int    checks   = 0;
  int    failures = 0;
  load_t exp_q [2][$];

  always #5 clk = ~clk;

  // Cycle index: equals the number of rising edges seen so far.
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_output(input string name, input logic [31:0] act,
                              input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Bit idx of a frame: data bits MSB first, then the parity of the word.
  function automatic logic exp_bit(input logic [20:0] w, input int idx);
    if (idx < 21) return w[20-idx];
    return ^w;
  endfunction

  for (genvar g = 0; g < 2; g++) begin : lane
    localparam int   D    = (g == 0) ? 1 : 4;
    localparam logic IDLE = (g == 0) ? 1'b1 : 1'b0;

    dip_serial_source #(
      .DIV     (D),
      .IDLE_LVL(IDLE)
    ) dut (
      .i_CLK      (clk),
      .i_RESET_n  (rst_n),
      .i_DIP16    (dip),
      .i_Switch5  (sw),
      .i_DIPLatch (latch),
      .o_DIPData  (data_o[g]),
      .o_Busy     (busy_o[g]),
      .o_FrameDone(done_o[g]),
      .o_BitCnt   (bcnt_o[g])
    );

    load_t cur;
    bit    active;
    logic  done_exp;
    int    el;

    // Time-driven reference. A frame in flight finishes when it reaches
    // L*D elapsed cycles. A queued load whose start cycle has arrived
    // replaces the current frame; if that frame was unfinished it is
    // aborted silently.
    initial begin
      active = 1'b0;
      forever begin
        @(negedge clk);
        if (!rst_n) begin
          active = 1'b0;
          check_output($sformatf("lane%0d reset data", g), data_o[g], IDLE);
          check_output($sformatf("lane%0d reset busy", g), busy_o[g], 0);
          check_output($sformatf("lane%0d reset done", g), done_o[g], 0);
          check_output($sformatf("lane%0d reset bitcnt", g), bcnt_o[g], 0);
        end else begin
          done_exp = 1'b0;
          if (active && (cyc - cur.start) == L * D) begin
            done_exp = 1'b1;
            active   = 1'b0;
          end
          if (exp_q[g].size() > 0 && exp_q[g][0].start == cyc) begin
            cur    = exp_q[g].pop_front();
            active = 1'b1;
          end
          check_output($sformatf("lane%0d done c%0d", g, cyc), done_o[g], done_exp);
          if (active) begin
            el = cyc - cur.start;
            check_output($sformatf("lane%0d busy c%0d", g, cyc), busy_o[g], 1);
            check_output($sformatf("lane%0d bitcnt c%0d", g, cyc), bcnt_o[g], el / D);
            check_output($sformatf("lane%0d data c%0d", g, cyc), data_o[g],
                         exp_bit(cur.w, el / D));
          end else begin
            check_output($sformatf("lane%0d idle busy c%0d", g, cyc), busy_o[g], 0);
            check_output($sformatf("lane%0d idle bitcnt c%0d", g, cyc), bcnt_o[g], 0);
            check_output($sformatf("lane%0d idle data c%0d", g, cyc), data_o[g], IDLE);
          end
        end
      end
    end
  end

  // Called just after a falling edge, with the strobe low. Raises the strobe
  // for 'hold' cycles and keeps the word stable until the load edge three
  // cycles later. It then scrambles the switch inputs until 'gap' cycles have
  // passed.
  task automatic apply_stimulus(input logic [20:0] w, input int hold, input int gap);
    load_t e;
    {sw, dip} = w;
    latch     = 1'b1;
    e.w       = w;
    e.start   = cyc + 3;
    exp_q[0].push_back(e);
    exp_q[1].push_back(e);
    for (int i = 0; i < gap; i++) begin
      @(negedge clk);
      #1;
      if (i + 1 == hold) latch = 1'b0;
      if (i >= 2) begin
        dip = 16'($urandom);
        sw  = 5'($urandom);
      end
    end
  endtask

  task automatic wait_cycles(input int n, output int busy1, output int done1);
    busy1 = 0;
    done1 = 0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (busy_o[1]) busy1++;
      if (done_o[1]) done1++;
      #1;
    end
  endtask

  int nb, nd, gap;

  initial begin
    $display("[TB] start, frame length %0d", L);
    wait_cycles(4, nb, nd);
    for (int g = 0; g < 2; g++) begin
      check_output($sformatf("lane%0d por busy", g), busy_o[g], 0);
      check_output($sformatf("lane%0d por done", g), done_o[g], 0);
      check_output($sformatf("lane%0d por bitcnt", g), bcnt_o[g], 0);
    end
    rst_n = 1'b1;
    wait_cycles(6, nb, nd);

    // Reference pattern, then an all-ones word whose lane-1 busy time is known.
    apply_stimulus({5'b10110, 16'hA5C3}, 1, 1);
    wait_cycles(100, nb, nd);
    check_output("lane1 done count pattern", nd, 1);
    apply_stimulus(21'h1FFFFF, 2, 2);
    wait_cycles(100, nb, nd);
    check_output("lane1 busy cycles all-ones", nb, 4 * L);
    check_output("lane1 done count all-ones", nd, 1);

    // Restart on lane 1 while it shows bit 7, with new switch contents.
    apply_stimulus(21'h0ABCDE, 1, 30);
    apply_stimulus({5'b00000, 16'h0001}, 1, 5);
    wait_cycles(100, nb, nd);
    check_output("lane1 done count after restart", nd, 1);

    // Loads landing exactly on the final cycle of each lane.
    apply_stimulus(21'h155555, 1, L);
    apply_stimulus(21'h0F0F0F, 1, 4 * L);
    apply_stimulus(21'h1A2B3C, 1, 4);
    wait_cycles(100, nb, nd);

    // Words whose parity is odd and even.
    apply_stimulus(21'h000007, 1, 100);
    apply_stimulus(21'h000003, 1, 100);

    for (int n = 0; n < 40; n++) begin
      case ($urandom_range(0, 9))
        0:       gap = L;
        1:       gap = 4 * L;
        2:       gap = $urandom_range(4, 12);
        default: gap = $urandom_range(5, 100);
      endcase
      apply_stimulus(21'($urandom), $urandom_range(1, 3), gap);
    end
    wait_cycles(100, nb, nd);

    // Strobe held high for a long time gives a single frame.
    apply_stimulus(21'h13579B, 100, 150);
    wait_cycles(20, nb, nd);

    // Reset while lane 1 shows bit 10; outputs must react before any clock
    // edge. The strobe stays high through reset and for a while afterwards.
    apply_stimulus(21'h0C3A5F, 1, 44);
    check_output("lane1 bitcnt before reset", bcnt_o[1], 10);
    rst_n = 1'b0;
    latch = 1'b1;
    #1;
    check_output("async reset busy", busy_o[1], 0);
    check_output("async reset bitcnt", bcnt_o[1], 0);
    check_output("async reset data", data_o[1], 0);
    check_output("async reset done", done_o[1], 0);
    exp_q[0].delete();
    exp_q[1].delete();
    wait_cycles(3, nb, nd);
    rst_n = 1'b1;
    wait_cycles(20, nb, nd);
    check_output("no load from held strobe", nb, 0);
    latch = 1'b0;
    wait_cycles(5, nb, nd);
    apply_stimulus(21'h1E01F0, 1, 1);
    wait_cycles(100, nb, nd);
    check_output("lane1 done count after reset", nd, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/dip_serial_source.md
DIP_SERIAL_SOURCE -- requirements
Module: dip_serial_source

Interface
REQ-001 SHALL have parameter DIV, default 1: number of i_CLK cycles each serial bit is held; legal range 1..255.
REQ-002 SHALL have parameter IDLE_LVL, default 1'b1: level driven on o_DIPData when no frame is in progress.
REQ-003 i_CLK  input  1  sole clock; all state updates on the rising edge.
REQ-004 i_RESET_n  input  1  reset, asynchronous and active-low.
REQ-005 i_DIP16  input  16  parallel DIP switch value, sampled at load.
REQ-006 i_Switch5  input  5  parallel push-switch value, sampled at load.
REQ-007 i_DIPLatch  input  1  load request from the DIP parallelizer, asynchronous to i_CLK.
REQ-008 o_DIPData  output  1  serial frame data.
REQ-009 o_Busy  output  1  high while a frame is shifting.
REQ-010 o_FrameDone  output  1  one-cycle pulse after the last bit of a frame.
REQ-011 o_BitCnt  output  5  index of the bit currently on o_DIPData; 0 when idle.

Function
REQ-012 SHALL synchronise i_DIPLatch through two flip-flops, then detect a rising edge (load event) from the synchronised value.
REQ-013 SHALL implement states IDLE and SHIFT.
REQ-014 On a load event in IDLE, SHALL capture W = {i_Switch5, i_DIP16} (21 bits) and enter SHIFT on the same edge.
REQ-015 Load latency: W[20] SHALL appear on o_DIPData in the cycle after the load event, i.e. 3 i_CLK edges after i_DIPLatch rises.
REQ-016 SHALL shift MSB first, W[20] down to W[0], and hold each bit for exactly DIV cycles, timed by an internal prescale counter reset at load.
REQ-017 o_BitCnt SHALL equal 0 for W[20] and increment by 1 per bit, reaching 20 for W[0].
REQ-018 After the last bit's hold period, SHALL return to IDLE, drive IDLE_LVL, deassert o_Busy, clear o_BitCnt and pulse o_FrameDone for exactly one cycle.
REQ-019 A load event during SHIFT SHALL abort the current frame, recapture W and restart from W[20]; no o_FrameDone is issued for the aborted frame.
REQ-020 A load event in the same cycle as the frame end SHALL be treated as a restart: o_FrameDone pulses and a new frame starts with no idle cycle.
REQ-021 Changes on i_DIP16/i_Switch5 during SHIFT SHALL NOT affect the frame in progress.
REQ-022 i_DIPLatch held high SHALL produce exactly one load event.

Reset
REQ-023 While i_RESET_n = 0: state IDLE, o_DIPData = IDLE_LVL, o_Busy = 0, o_FrameDone = 0, o_BitCnt = 0; synchroniser, edge detector and prescale counter cleared.
REQ-024 Reset asserted mid-frame SHALL abort the frame immediately, asynchronously, with no o_FrameDone.
REQ-025 After reset release, a high i_DIPLatch SHALL not create a load event until it has gone low and then high again.

Configuration
REQ-026 Macro DIP_SERIAL_PARITY_EN defined: the frame SHALL append one even-parity bit over W[20:0] after W[0], with o_BitCnt = 21; the frame is 22 bits.
REQ-027 Macro DIP_SERIAL_PARITY_EN undefined: the frame SHALL be 21 bits with no parity logic.

Verification
REQ-028 Reset, DIV=1, i_DIP16=16'hA5C3, i_Switch5=5'b10110, pulse i_DIPLatch -> W[20] appears 3 edges after the latch; o_DIPData serialises 1,0,1,1,0 then A5C3 MSB first, one bit per cycle; o_FrameDone pulses once; idle level is 1.
REQ-029 DIV=4, W=21'h1FFFFF -> o_Busy is high for exactly 84 cycles; o_BitCnt steps every 4 cycles, 0 to 20.
REQ-030 Second latch pulse at o_BitCnt=7, with i_DIP16 changed to 16'h0001 -> the frame restarts at bit 0 with the new value; only one o_FrameDone is seen, after the second frame.
REQ-031 Assert i_RESET_n=0 at o_BitCnt=10 -> outputs go to reset values without waiting for a clock edge; no o_FrameDone.
REQ-032 DIP_SERIAL_PARITY_EN defined, W=21'h000007 -> 22 bits shifted, final bit 1; with W=21'h000003 the final bit is 0.
REQ-033 i_DIPLatch held high for 100 cycles -> exactly one frame is produced.
